fir_folded: RTL and testbench
=============================

# fir_folded

Parametrised, time-multiplexed FIR filter: next generation of the 8-bit/16-bit `fir` block. One multiply-accumulate unit is shared across all taps. Tap count, data/coefficient/output widths and signed/unsigned arithmetic are parameters. Adds a `ready` handshake, output saturation and sticky protocol-error reporting. Sits between the sample source and the downstream datapath, keeping the same load-coefficients-then-stream protocol as `fir`.

## Interface
- `TAPS`, 5, number of taps/coefficients (≥2)
- `DATA_W`, 8, sample width
- `COEF_W`, 8, coefficient width
- `OUT_W`, 16, output width
- `SIGNED`, 0, 1 = two's-complement samples/coefficients/output; 0 = unsigned

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `data_in`  in  max(DATA_W,COEF_W)  coefficient (low COEF_W bits) or sample (low DATA_W bits)
- `coef_enable`  in  1  coefficient write strobe
- `sample_enable`  in  1  sample strobe; accepted only when `ready`=1
- `data_out`  out  OUT_W  filter result; held between results
- `out_enable`  out  1  one-cycle pulse when `data_out` updates
- `ready`  out  1  block can accept a sample this cycle
- `error`  out  1  sticky protocol error; cleared only by reset

## Operation
- States: LOAD, READY, MAC, DONE.
- Reset: state=LOAD, coef index=0, all coefficients=0, delay line=0, acc=0, `data_out`=0, `out_enable`=0, `ready`=0, `error`=0.
- LOAD:
  - `coef_enable`=1 and index<TAPS: coef[index]←data_in, index++.
  - `coef_enable`=1 and index==TAPS: write ignored, `error`←1.
  - `coef_enable`=0: go to READY. Unwritten coefficients stay 0.
  - `sample_enable`=1 in LOAD: sample ignored, `error`←1.
- READY (`ready`=1):
  - `coef_enable`=1: reload. Index←0, delay line cleared, first write taken this cycle, go to LOAD.
  - `coef_enable`=0 and `sample_enable`=1: shift delay line (x[0]←data_in, x[i]←x[i-1]), acc←0, tap←0, go to MAC.
- MAC: each cycle acc ← acc + x[tap]·coef[tap], tap++. After the tap==TAPS-1 update, go to DONE.
- DONE: `data_out`←sat(acc), `out_enable`←1, go to READY.
- Both strobes high in the same cycle, any state: coefficient path wins, `error`←1.
- `sample_enable` or `coef_enable` in MAC/DONE: ignored, `error`←1. The computation is unaffected.
- Arithmetic:
  - Product width DATA_W+COEF_W.
  - ACC_W = DATA_W+COEF_W+clog2(TAPS); the accumulator never wraps.
  - sat(): SIGNED=0 clamps to [0, 2^OUT_W−1]; SIGNED=1 clamps to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - If ACC_W ≤ OUT_W: extend (sign- or zero-) instead of saturating.
- Reset mid-MAC/DONE: computation aborted, no `out_enable` pulse, full reset state.

## Timing
- Sample accepted at edge E0.
- MAC updates at E1..E_TAPS.
- `data_out` and `out_enable` registered at E_{TAPS+1}: latency TAPS+1 cycles.
- `out_enable` high for exactly one cycle.
- `ready` deasserts the cycle after E0 and reasserts after E_{TAPS+1}. Max throughput: one sample per TAPS+2 cycles.
- `error` rises the cycle after the offending strobe edge.
- All outputs are registered; no combinational input→output path.

## Structure
- Package `fir_pkg`:
  - state enum
  - `acc_width(DATA_W, COEF_W, TAPS)` function
  - saturate function parameterised by SIGNED/width
- Sub-module `fir_mac_unit`: registered multiply-accumulate with a clear input and a SIGNED parameter. Instantiated once.
- Top holds the FSM, coefficient register file, delay line, tap counter and output register.

## Test plan
All scenarios use default parameters unless stated.

1. Load coefficients 4,5,6,7,8, one idle cycle, then five samples of 1 → `data_out` 4, 9, 15, 22, 30, each with a single `out_enable` pulse 6 cycles after acceptance; `error`=0.
2. Write 12 coefficients 4..15 → `error`=1 from the 6th write onward; coefficients hold 4..8. Sample 1 → `data_out`=4.
3. All coefficients 255, samples 255, 255 → `data_out` 65025, then 65535 (saturated, true value 130050).
4. SIGNED=1, coefficients −1,0,0,0,0, sample 0x80 (−128) → `data_out`=128. Sample 0x7F → −127 (0xFF81).
5. Assert `sample_enable` during MAC, and both strobes together in READY → `error`=1. The in-flight result is still correct; the second case performs a coefficient write and starts LOAD.
6. Reset asserted 2 cycles into MAC → no `out_enable`. Next cycle: `data_out`=0, `ready`=0, state LOAD. A new sample after reload yields a result from a zero delay line.

Source files
------------

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the folded FIR filter:
//   - fir_state_e : controller state encoding (LOAD, READY, MAC, DONE)
//   - acc_width() : accumulator width that cannot wrap over TAPS products
//   - saturate()  : clamps a sign/zero-extended value to an OUT_W-bit range
// No ports (package).
// -----------------------------------------------------------------------------
package fir_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_MAC   = 2'd2,
    ST_DONE  = 2'd3
  } fir_state_e;

  // Working width of the saturation helper; any accumulator is extended to it.
  localparam int SAT_W = 64;

  // Sum of TAPS products of DATA_W x COEF_W bits needs clog2(TAPS) guard bits.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Clamp val (already extended to SAT_W bits) to the out_w-bit range. When the
  // value already fits, it is returned unchanged, so callers with a narrow
  // accumulator get plain sign/zero extension after truncating to out_w bits.
  function automatic logic [SAT_W-1:0] saturate(input logic [SAT_W-1:0] val,
                                                input int               out_w,
                                                input bit               is_signed);
    logic signed [SAT_W-1:0] sval;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sval = signed'(val);
    if (is_signed) begin
      max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (out_w - 1));
    end else begin
      max_v = (64'sd1 <<< out_w) - 64'sd1;
      min_v = 64'sd0;
    end
    if (sval > max_v) return max_v;
    if (sval < min_v) return min_v;
    return val;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// -----------------------------------------------------------------------------
// fir_mac_unit
// Registered multiply-accumulate shared by all taps of the folded FIR.
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset (acc <= 0)
//   clear_i  in   synchronous clear of the accumulator (priority over en_i)
//   en_i     in   accumulate x_i * c_i this cycle
//   x_i      in   sample operand   (DATA_W)
//   c_i      in   coefficient      (COEF_W)
//   acc_o    out  accumulator      (ACC_W)
// SIGNED=1 treats operands as two's complement, SIGNED=0 as unsigned.
// -----------------------------------------------------------------------------
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 19,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [COEF_W-1:0] c_i,
  output logic [ACC_W-1:0]  acc_o
);

  localparam int PROD_W    = DATA_W + COEF_W;
  localparam bit IS_SIGNED = (SIGNED != 0);

  logic [PROD_W-1:0] x_ext;
  logic [PROD_W-1:0] c_ext;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  acc_q;

  // Extending both operands to the full product width makes the low PROD_W
  // bits of an unsigned multiply correct for two's-complement inputs as well.
  always_comb begin
    x_ext    = {{COEF_W{IS_SIGNED & x_i[DATA_W-1]}}, x_i};
    c_ext    = {{DATA_W{IS_SIGNED & c_i[COEF_W-1]}}, c_i};
    prod     = x_ext * c_ext;
    prod_ext = {{(ACC_W-PROD_W){IS_SIGNED & prod[PROD_W-1]}}, prod};
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + prod_ext;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_folded.sv
// -----------------------------------------------------------------------------
// fir_folded
// Time-multiplexed FIR: one MAC serves all TAPS taps, one result per sample.
// Protocol: load coefficients (coef_enable burst), then stream samples.
//   clk            in   clock, rising edge
//   reset          in   synchronous active-high reset
//   data_in        in   coefficient (low COEF_W bits) or sample (low DATA_W)
//   coef_enable    in   coefficient write strobe
//   sample_enable  in   sample strobe, accepted only while ready=1
//   data_out       out  saturated filter result, held between results
//   out_enable     out  one-cycle pulse when data_out updates
//   ready          out  a sample can be accepted this cycle
//   error          out  sticky protocol error, cleared only by reset
// Latency from sample acceptance to out_enable is TAPS+1 cycles.
// -----------------------------------------------------------------------------
module fir_folded
  import fir_pkg::*;
#(
  parameter  int TAPS   = 5,
  parameter  int DATA_W = 8,
  parameter  int COEF_W = 8,
  parameter  int OUT_W  = 16,
  parameter  int SIGNED = 0,
  localparam int IN_W   = (DATA_W > COEF_W) ? DATA_W : COEF_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  data_in,
  input  logic             coef_enable,
  input  logic             sample_enable,
  output logic [OUT_W-1:0] data_out,
  output logic             out_enable,
  output logic             ready,
  output logic             error
);

  localparam int ACC_W     = acc_width(DATA_W, COEF_W, TAPS);
  localparam int IDX_W     = $clog2(TAPS + 1);
  localparam int TAP_W     = $clog2(TAPS);
  localparam bit IS_SIGNED = (SIGNED != 0);

  localparam logic [1:0] LOAD  = ST_LOAD;
  localparam logic [1:0] READY = ST_READY;
  localparam logic [1:0] MAC   = ST_MAC;
  localparam logic [1:0] DONE  = ST_DONE;

  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(TAPS);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [OUT_W-1:0]  data_out_q, data_out_d;
  logic              out_en_q, out_en_d;
  logic              ready_q;
  logic              error_q, error_d;

  logic [COEF_W-1:0] coef_q [TAPS];
  logic [DATA_W-1:0] x_q    [TAPS];

  logic              coef_we;
  logic [TAP_W-1:0]  coef_waddr;
  logic              x_shift;
  logic              x_clear;
  logic              mac_clear;
  logic              mac_en;
  logic [ACC_W-1:0]  acc;
  logic [SAT_W-1:0]  acc_ext;

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clear_i (mac_clear),
    .en_i    (mac_en),
    .x_i     (x_q[tap_q]),
    .c_i     (coef_q[tap_q]),
    .acc_o   (acc)
  );

  assign acc_ext = {{(SAT_W-ACC_W){IS_SIGNED & acc[ACC_W-1]}}, acc};

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tap_d      = tap_q;
    data_out_d = data_out_q;
    out_en_d   = 1'b0;
    error_d    = error_q;
    coef_we    = 1'b0;
    coef_waddr = TAP_W'(idx_q);
    x_shift    = 1'b0;
    x_clear    = 1'b0;
    mac_clear  = 1'b0;
    mac_en     = 1'b0;

    // Both strobes at once is a protocol error; the coefficient path wins.
    if (coef_enable && sample_enable) error_d = 1'b1;

    case (state_q)
      LOAD: begin
        if (coef_enable) begin
          if (idx_q < IDX_FULL) begin
            coef_we = 1'b1;
            idx_d   = idx_q + 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end else begin
          state_d = READY;
          if (sample_enable) error_d = 1'b1;
        end
      end
      READY: begin
        if (coef_enable) begin
          // Reload: restart at index 0 and take this cycle's write as coef[0].
          coef_we    = 1'b1;
          coef_waddr = '0;
          idx_d      = IDX_W'(1);
          x_clear    = 1'b1;
          state_d    = LOAD;
        end else if (sample_enable) begin
          x_shift   = 1'b1;
          mac_clear = 1'b1;
          tap_d     = '0;
          state_d   = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        tap_d  = tap_q + 1'b1;
        if (tap_q == TAP_LAST) state_d = DONE;
        if (coef_enable || sample_enable) error_d = 1'b1;
      end
      DONE: begin
        data_out_d = OUT_W'(saturate(acc_ext, OUT_W, IS_SIGNED));
        out_en_d   = 1'b1;
        state_d    = READY;
        if (coef_enable || sample_enable) error_d = 1'b1;
      end
      default: state_d = LOAD;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOAD;
      idx_q      <= '0;
      tap_q      <= '0;
      data_out_q <= '0;
      out_en_q   <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      // NOTE: the coefficient and delay-line arrays are reset explicitly because
      // unwritten taps must read as zero; this keeps them in flops, not RAM.
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
        x_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tap_q      <= tap_d;
      data_out_q <= data_out_d;
      out_en_q   <= out_en_d;
      ready_q    <= (state_d == READY);
      error_q    <= error_d;
      if (coef_we) coef_q[coef_waddr] <= data_in[COEF_W-1:0];
      if (x_clear) begin
        for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
      end else if (x_shift) begin
        x_q[0] <= data_in[DATA_W-1:0];
        for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
      end
    end
  end

  assign data_out   = data_out_q;
  assign out_enable = out_en_q;
  assign ready      = ready_q;
  assign error      = error_q;

endmodule

// File: tb/tb_fir_folded.sv
// -----------------------------------------------------------------------------
// tb_fir_folded
// Drives an unsigned (default) and a signed (SIGNED=1) fir_folded from the same
// inputs. A behavioural model (coefficient table + sample history, plain
// integer dot product and clamp) predicts both outputs.
// -----------------------------------------------------------------------------
module tb_fir_folded;

  localparam int TAPS = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        coef_enable;
  logic        sample_enable;
  logic [15:0] data_out_u, data_out_s;
  logic        out_enable_u, out_enable_s;
  logic        ready_u, ready_s;
  logic        error_u, error_s;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state.
  logic [7:0]  m_coef [TAPS];
  logic [7:0]  m_x    [TAPS];
  int          m_idx;
  bit          m_err;
  logic [7:0]  cq [$];
  logic [15:0] got_u, got_s;

  fir_folded u_dut_u (
    .clk(clk), .reset(reset), .data_in(data_in),
    .coef_enable(coef_enable), .sample_enable(sample_enable),
    .data_out(data_out_u), .out_enable(out_enable_u),
    .ready(ready_u), .error(error_u)
  );

  fir_folded #(.SIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .data_in(data_in),
    .coef_enable(coef_enable), .sample_enable(sample_enable),
    .data_out(data_out_s), .out_enable(out_enable_s),
    .ready(ready_s), .error(error_s)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_out(input bit sgn);
    longint acc;
    longint xv, cv;
    logic [15:0] r;
    acc = 0;
    for (int i = 0; i < TAPS; i++) begin
      xv  = sgn ? longint'($signed(m_x[i]))    : longint'(m_x[i]);
      cv  = sgn ? longint'($signed(m_coef[i])) : longint'(m_coef[i]);
      acc = acc + xv * cv;
    end
    if (sgn) begin
      if (acc > 32767)  acc = 32767;
      if (acc < -32768) acc = -32768;
    end else begin
      if (acc > 65535) acc = 65535;
    end
    r = acc[15:0];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      m_coef[i] = 8'd0;
      m_x[i]    = 8'd0;
    end
    m_idx = 0;
    m_err = 1'b0;
  endtask

  task automatic model_coef_write(input logic [7:0] v);
    if (m_idx < TAPS) begin
      m_coef[m_idx] = v;
      m_idx++;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1; coef_enable = 1'b0; sample_enable = 1'b0; data_in = 8'd0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  // Writes the queue cq as a coefficient burst, then one idle cycle.
  task automatic load_coefs();
    m_idx = 0;
    for (int i = 0; i < TAPS; i++) m_x[i] = 8'd0;
    foreach (cq[i]) begin
      coef_enable = 1'b1;
      data_in     = cq[i];
      model_coef_write(cq[i]);
      tick();
    end
    coef_enable = 1'b0;
    tick();
  endtask

  // Sends one sample; poke_at>0 asserts sample_enable again that many cycles
  // after acceptance (a protocol error that must not disturb the result).
  task automatic send_sample(input logic [7:0] v, input int poke_at);
    logic [15:0] exp_u, exp_s;
    int lat;
    for (int w = 0; w < 50 && ready_u !== 1'b1; w++) tick();
    n_cmp++;
    if (ready_u !== 1'b1) begin
      n_err++;
      $display("FAIL ready_wait: ready=%b, want 1 within 50 cycles", ready_u);
      return;
    end
    sample_enable = 1'b1;
    data_in       = v;
    tick();
    sample_enable = 1'b0;
    for (int i = TAPS - 1; i > 0; i--) m_x[i] = m_x[i-1];
    m_x[0] = v;
    exp_u = model_out(1'b0);
    exp_s = model_out(1'b1);
    n_cmp++;
    if (ready_u !== 1'b0) begin
      n_err++;
      $display("FAIL ready_after_accept: got %b want 0", ready_u);
    end
    lat = 0;
    for (int k = 1; k <= TAPS + 4; k++) begin
      if (k == poke_at) begin
        sample_enable = 1'b1;
        data_in       = 8'hA5;
        m_err         = 1'b1;
      end
      tick();
      sample_enable = 1'b0;
      if (out_enable_u === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_cmp++;
    if (lat != TAPS + 1) begin
      n_err++;
      $display("FAIL latency: got %0d cycles want %0d", lat, TAPS + 1);
    end
    n_cmp++;
    if (out_enable_s !== 1'b1) begin
      n_err++;
      $display("FAIL signed_out_enable: got %b want 1", out_enable_s);
    end
    n_cmp++;
    if (data_out_u !== exp_u) begin
      n_err++;
      $display("FAIL data_u: sample %0d got %0d want %0d", v, data_out_u, exp_u);
    end
    n_cmp++;
    if (data_out_s !== exp_s) begin
      n_err++;
      $display("FAIL data_s: sample 0x%h got 0x%h want 0x%h", v, data_out_s, exp_s);
    end
    n_cmp++;
    if (ready_u !== 1'b1) begin
      n_err++;
      $display("FAIL ready_with_result: got %b want 1", ready_u);
    end
    got_u = data_out_u;
    got_s = data_out_s;
    tick();
    n_cmp++;
    if (out_enable_u !== 1'b0 || out_enable_s !== 1'b0) begin
      n_err++;
      $display("FAIL pulse_width: out_enable u=%b s=%b want 0", out_enable_u, out_enable_s);
    end
  endtask

  task automatic check_error_flags(input string name);
    n_cmp++;
    if (error_u !== m_err || error_s !== m_err) begin
      n_err++;
      $display("FAIL %s: error u=%b s=%b want %b", name, error_u, error_s, m_err);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    n_cmp++;
    if (data_out_u !== 16'd0 || out_enable_u !== 1'b0 || ready_u !== 1'b0 || error_u !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: data=%0d oe=%b rdy=%b err=%b want 0 0 0 0",
               data_out_u, out_enable_u, ready_u, error_u);
    end
    tick();
    n_cmp++;
    if (ready_u !== 1'b1) begin
      n_err++;
      $display("FAIL load_to_ready: ready=%b want 1", ready_u);
    end
    send_sample(8'd200, 0);
    n_cmp++;
    if (got_u !== 16'd0) begin
      n_err++;
      $display("FAIL zero_coefs: got %0d want 0", got_u);
    end
  endtask

  task automatic test_basic();
    int exp_t [5] = '{4, 9, 15, 22, 30};
    reset_dut();
    cq.delete();
    for (int i = 0; i < TAPS; i++) cq.push_back(8'(4 + i));
    load_coefs();
    for (int i = 0; i < 5; i++) begin
      send_sample(8'd1, 0);
      n_cmp++;
      if (got_u !== 16'(exp_t[i])) begin
        n_err++;
        $display("FAIL basic_step%0d: got %0d want %0d", i, got_u, exp_t[i]);
      end
    end
    check_error_flags("basic_error");
  endtask

  task automatic test_coef_overflow();
    reset_dut();
    m_idx = 0;
    for (int i = 0; i < 12; i++) begin
      coef_enable = 1'b1;
      data_in     = 8'(4 + i);
      model_coef_write(8'(4 + i));
      tick();
      n_cmp++;
      if (error_u !== (i >= 5)) begin
        n_err++;
        $display("FAIL overflow_write%0d: error=%b want %b", i + 1, error_u, (i >= 5));
      end
    end
    coef_enable = 1'b0;
    tick();
    send_sample(8'd1, 0);
    n_cmp++;
    if (got_u !== 16'd4) begin
      n_err++;
      $display("FAIL overflow_result: got %0d want 4", got_u);
    end
    check_error_flags("overflow_sticky");
  endtask

  task automatic test_saturation();
    reset_dut();
    cq.delete();
    for (int i = 0; i < TAPS; i++) cq.push_back(8'd255);
    load_coefs();
    send_sample(8'd255, 0);
    n_cmp++;
    if (got_u !== 16'd65025) begin
      n_err++;
      $display("FAIL sat_first: got %0d want 65025", got_u);
    end
    send_sample(8'd255, 0);
    n_cmp++;
    if (got_u !== 16'd65535) begin
      n_err++;
      $display("FAIL sat_clamp: got %0d want 65535", got_u);
    end
  endtask

  task automatic test_signed();
    reset_dut();
    cq.delete();
    cq.push_back(8'hFF);
    for (int i = 1; i < TAPS; i++) cq.push_back(8'h00);
    load_coefs();
    send_sample(8'h80, 0);
    n_cmp++;
    if (got_s !== 16'h0080) begin
      n_err++;
      $display("FAIL signed_neg: got 0x%h want 0x0080", got_s);
    end
    send_sample(8'h7F, 0);
    n_cmp++;
    if (got_s !== 16'hFF81) begin
      n_err++;
      $display("FAIL signed_pos: got 0x%h want 0xff81", got_s);
    end
  endtask

  task automatic test_protocol_errors();
    reset_dut();
    cq.delete();
    for (int i = 0; i < TAPS; i++) cq.push_back(8'(i + 1));
    load_coefs();
    check_error_flags("proto_clean");
    send_sample(8'd3, 2);
    check_error_flags("proto_mac_strobe");
    // Both strobes in READY: reload starts with this write.
    coef_enable   = 1'b1;
    sample_enable = 1'b1;
    data_in       = 8'd9;
    m_idx = 0;
    for (int i = 0; i < TAPS; i++) m_x[i] = 8'd0;
    model_coef_write(8'd9);
    m_err = 1'b1;
    tick();
    sample_enable = 1'b0;
    n_cmp++;
    if (ready_u !== 1'b0) begin
      n_err++;
      $display("FAIL both_strobes_load: ready=%b want 0", ready_u);
    end
    check_error_flags("proto_both_strobes");
    for (int i = 0; i < TAPS - 1; i++) begin
      data_in = 8'(10 + i);
      model_coef_write(8'(10 + i));
      tick();
    end
    coef_enable = 1'b0;
    tick();
    send_sample(8'd2, 0);
    n_cmp++;
    if (got_u !== 16'd18) begin
      n_err++;
      $display("FAIL both_strobes_reload: got %0d want 18", got_u);
    end
  endtask

  task automatic test_reset_mid_mac();
    bit saw_pulse;
    reset_dut();
    cq.delete();
    for (int i = 0; i < TAPS; i++) cq.push_back(8'(i + 1));
    load_coefs();
    sample_enable = 1'b1;
    data_in       = 8'd7;
    tick();
    sample_enable = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    n_cmp++;
    if (out_enable_u !== 1'b0 || data_out_u !== 16'd0 || ready_u !== 1'b0 || error_u !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state: oe=%b data=%0d rdy=%b err=%b want 0 0 0 0",
               out_enable_u, data_out_u, ready_u, error_u);
    end
    saw_pulse = 1'b0;
    for (int i = 0; i < TAPS + 3; i++) begin
      tick();
      if (out_enable_u !== 1'b0 || out_enable_s !== 1'b0) saw_pulse = 1'b1;
    end
    n_cmp++;
    if (saw_pulse) begin
      n_err++;
      $display("FAIL abort_no_pulse: got a pulse want none");
    end
    cq.delete();
    for (int i = 0; i < TAPS; i++) cq.push_back(8'(i + 2));
    load_coefs();
    send_sample(8'd5, 0);
    n_cmp++;
    if (got_u !== 16'd10) begin
      n_err++;
      $display("FAIL abort_fresh_line: got %0d want 10", got_u);
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int r = 0; r < 4; r++) begin
      cq.delete();
      for (int i = 0; i < int'($urandom_range(2, 7)); i++) cq.push_back(8'($urandom));
      load_coefs();
      for (int s = 0; s < 6; s++) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        send_sample(8'($urandom), 0);
      end
      check_error_flags("random_error");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_coef_overflow();
    test_saturation();
    test_signed();
    test_protocol_errors();
    test_reset_mid_mac();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
